muldiv_sequencer: RTL and testbench

//   Multi-cycle sequencer for the M-extension ops (mul, divu, remu) of the single-cycle RV32 core.

---
 rtl/muldiv_sequencer.sv | 133 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned mul/divu/remu sequencer for the RV32 M-extension.
// Ports: clk, reset_n, start, op, a, b in; busy, done, stall, result out.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_RSV  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [1:0]       op_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH:0]   acc_q;
    logic [CW-1:0]    count;

    logic accept;
    logic last;

    // x holds multiplier (mul) or dividend/quotient (div);
    // y holds multiplicand (mul) or divisor (div);
    // acc holds product (mul) or partial remainder (div).
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             borrow;
    logic [WIDTH:0]   acc_nxt;
    logic [WIDTH-1:0] x_nxt;
    logic [WIDTH-1:0] y_nxt;
    logic [WIDTH-1:0] res_nxt;

    assign accept = (state == IDLE) && start && (op != OP_RSV);
    assign last   = (count == CW'(WIDTH - 1));

    // Gated by reset_n so a held start cannot stall the core in reset.
    assign stall = reset_n && (accept || (state == BUSY));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        shifted = {acc_q[WIDTH-1:0], x_q[WIDTH-1]};
        trial   = {1'b0, shifted} - {2'b00, y_q};
        borrow  = trial[WIDTH+1];
        acc_nxt = acc_q;
        x_nxt   = x_q;
        y_nxt   = y_q;
        if (op_q == OP_MUL) begin
            if (x_q[0]) begin
                acc_nxt = {1'b0, acc_q[WIDTH-1:0] + y_q};
            end
            x_nxt = x_q >> 1;
            y_nxt = y_q << 1;
        end else begin
            acc_nxt = borrow ? shifted : trial[WIDTH:0];
            x_nxt   = {x_q[WIDTH-2:0], ~borrow};
        end
        res_nxt = (op_q == OP_DIVU) ? x_nxt : acc_nxt[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q   <= 2'b00;
            x_q    <= '0;
            y_q    <= '0;
            acc_q  <= '0;
            count  <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            busy <= (state_nxt == BUSY);
            done <= (state_nxt == DONE);
            if (accept) begin
                op_q  <= op;
                count <= '0;
                acc_q <= '0;
                if (op == OP_MUL) begin
                    x_q <= b;
                    y_q <= a;
                end else begin
                    x_q <= a;
                    y_q <= b;
                end
            end else if (state == BUSY) begin
                count <= count + 1'b1;
                acc_q <= acc_nxt;
                x_q   <= x_nxt;
                y_q   <= y_nxt;
                if (last) begin
                    result <= res_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer.
// Reference results come from plain *, / and % arithmetic.
module tb_muldiv_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .stall   (stall),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        case (o)
            2'd0:    return x * y;
            2'd1:    return (y == 0) ? 32'hFFFF_FFFF : x / y;
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after DONE.
    task automatic run_op(input logic [1:0] o,
                          input logic [31:0] x,
                          input logic [31:0] y,
                          input bit hold,
                          input string tag);
        int stalls;
        int busys;
        int cyc;
        logic [31:0] exp;
        exp   = model(o, x, y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        #1;
        stalls = int'(stall);
        busys  = 0;
        cyc    = 0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (done) begin
                cyc = i;
                break;
            end
            stalls += int'(stall);
            busys  += int'(busy);
            if (!hold) begin
                a     = $urandom;
                b     = $urandom;
                op    = 2'($urandom);
                start = 1'($urandom);
            end
        end
        check({tag, " done_cycle"}, cyc, 33);
        check({tag, " stall_cycles"}, stalls, 33);
        check({tag, " busy_cycles"}, busys, 32);
        check({tag, " result"}, result, exp);
        if (!hold) start = 1'b0;
        @(negedge clk);
        check({tag, " done_pulse"}, {31'd0, done}, 0);
        check({tag, " busy_after"}, {31'd0, busy}, 0);
        check({tag, " stall_after"}, {31'd0, stall}, {31'd0, hold});
        check({tag, " result_held"}, result, exp);
    endtask

    initial begin
        logic [31:0] x;
        logic [31:0] y;
        logic [1:0]  o;
        reset_n = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        a       = '0;
        b       = '0;
        repeat (3) @(negedge clk);
        check("rst busy", {31'd0, busy}, 0);
        check("rst done", {31'd0, done}, 0);
        check("rst stall", {31'd0, stall}, 0);
        check("rst result", result, 0);
        reset_n = 1'b1;
        @(negedge clk);

        run_op(2'd0, 32'd7, 32'd6, 1'b0, "mul7x6");
        run_op(2'd1, 32'd100, 32'd7, 1'b0, "divu100_7");
        run_op(2'd2, 32'd100, 32'd7, 1'b0, "remu100_7");
        run_op(2'd1, 32'd5, 32'd0, 1'b0, "divu_by0");
        run_op(2'd2, 32'd5, 32'd0, 1'b0, "remu_by0");
        run_op(2'd0, 32'h0001_0000, 32'h0001_0000, 1'b0, "mul_wrap");
        run_op(2'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, "mul_ff_x2");

        for (int n = 0; n < 20; n++) begin
            o = 2'($urandom_range(0, 2));
            x = $urandom;
            y = $urandom;
            if (n % 5 == 1) y = 0;
            if (n % 5 == 2) y = y >> $urandom_range(8, 31);
            if (n % 5 == 3) x = x >> $urandom_range(8, 31);
            run_op(o, x, y, 1'b0, $sformatf("rand%0d", n));
        end

        // Abort mid-operation with an async reset.
        start = 1'b1;
        op    = 2'd0;
        a     = 32'd3;
        b     = 32'd4;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 5) begin
                a = 32'hDEAD_BEEF;
                b = 32'h1234_5678;
            end
        end
        #2 reset_n = 1'b0;
        #1;
        check("abort busy", {31'd0, busy}, 0);
        check("abort stall", {31'd0, stall}, 0);
        check("abort done", {31'd0, done}, 0);
        check("abort result", result, 0);
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_op(2'd0, 32'd3, 32'd4, 1'b0, "mul3x4_post_rst");

        // Start held through DONE re-accepts after one idle cycle.
        run_op(2'd0, 32'd9, 32'd11, 1'b1, "hold1");
        run_op(2'd0, 32'd9, 32'd11, 1'b0, "hold2");

        // Reserved op is ignored.
        start = 1'b1;
        op    = 2'b11;
        a     = 32'd1;
        b     = 32'd1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rsv stall", {31'd0, stall}, 0);
            @(negedge clk);
            check("rsv busy", {31'd0, busy}, 0);
            check("rsv done", {31'd0, done}, 0);
        end
        start = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
